// File: rtl/spi_status_csr.sv
// Avalon-MM status/CSR slave for NUM_CH SpeedSPI channels: sticky W1C status,
// per-done CRC snapshots, saturating event counters and a maskable level irq.
module spi_status_csr #(
    parameter int NUM_CH = 4,
    parameter int CRC_W  = 32,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    avs_s0_write,
    input  logic                    avs_s0_read,
    input  logic [ADDR_W-1:0]       avs_s0_address,
    input  logic [31:0]             avs_s0_writedata,
    output logic [31:0]             avs_s0_readdata,
    output logic                    avs_s0_readdatavalid,
    input  logic [NUM_CH-1:0]       ch_error,
    input  logic [NUM_CH-1:0]       ch_done,
    input  logic [NUM_CH*CRC_W-1:0] crc_out,
    output logic                    irq
);

    // Read handshake: a read is accepted in every cycle it is asserted (no
    // waitrequest); readdatavalid is high exactly in the following cycle with
    // the pre-update register value, and readdata is zero in all other cycles.

    localparam logic [ADDR_W-1:0] A_CH_END = ADDR_W'(NUM_CH * 8);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(32'h80);
    localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'(32'h81);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h82);
    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(32'h83);
    localparam logic [31:0]       ID_VAL   = {8'h53, 8'(NUM_CH), 8'(CRC_W), 8'(CNT_W)};

    logic [NUM_CH-1:0]            err_q, err_d;
    logic [NUM_CH-1:0]            done_q, done_d;
    logic [NUM_CH-1:0]            ovr_q, ovr_d;
    logic [NUM_CH-1:0][CRC_W-1:0] crc_q, crc_d;
    logic [NUM_CH-1:0][CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [NUM_CH-1:0]            mask_q, mask_d;
    logic [31:0]                  readdata_q, readdata_d;
    logic                         rvalid_q;
    logic                         irq_q;

    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] pend;
    logic [ADDR_W-4:0] ch_idx;
    logic [2:0]        off;
    logic              in_ch;
    logic              ctrl_clr;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign ch_idx       = avs_s0_address[ADDR_W-1:3];
    assign off          = avs_s0_address[2:0];
    assign in_ch        = avs_s0_address < A_CH_END;
    assign ctrl_clr     = avs_s0_write && (avs_s0_address == A_CTRL) && avs_s0_writedata[0];
    assign pend         = (err_q | done_q) & mask_q;
    assign unused_wdata = ^avs_s0_writedata;

    always_comb begin
        ch_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel[c] = in_ch && (ch_idx == (ADDR_W-3)'(c));
        end
    end

    // Clears are applied first so that a same-cycle event always wins.
    always_comb begin
        err_d      = err_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        crc_d      = crc_q;
        err_cnt_d  = err_cnt_q;
        done_cnt_d = done_cnt_q;
        mask_d     = mask_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_clr || (avs_s0_write && ch_sel[c] && off == 3'd0 && avs_s0_writedata[0]))
                err_d[c] = 1'b0;
            if (ctrl_clr || (avs_s0_write && ch_sel[c] && off == 3'd0 && avs_s0_writedata[1]))
                done_d[c] = 1'b0;
            if (ctrl_clr || (avs_s0_write && ch_sel[c] && off == 3'd0 && avs_s0_writedata[2]))
                ovr_d[c] = 1'b0;
            if (ch_error[c])
                err_d[c] = 1'b1;
            if (ch_done[c]) begin
                done_d[c] = 1'b1;
                crc_d[c]  = crc_out[c*CRC_W +: CRC_W];
                if (done_q[c])
                    ovr_d[c] = 1'b1;
            end

            if (ctrl_clr || (avs_s0_write && ch_sel[c] && off == 3'd2))
                err_cnt_d[c] = '0;
            if (ch_error[c] && (err_cnt_d[c] != '1))
                err_cnt_d[c] = err_cnt_d[c] + CNT_W'(1);

            if (ctrl_clr || (avs_s0_write && ch_sel[c] && off == 3'd3))
                done_cnt_d[c] = '0;
            if (ch_done[c] && (done_cnt_d[c] != '1))
                done_cnt_d[c] = done_cnt_d[c] + CNT_W'(1);
        end
        if (avs_s0_write && avs_s0_address == A_MASK)
            mask_d = avs_s0_writedata[NUM_CH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) begin
                case (off)
                    3'd0:    rd_mux = 32'({ovr_q[c], done_q[c], err_q[c]});
                    3'd1:    rd_mux = 32'(crc_q[c]);
                    3'd2:    rd_mux = 32'(err_cnt_q[c]);
                    3'd3:    rd_mux = 32'(done_cnt_q[c]);
                    default: rd_mux = '0;
                endcase
            end
        end
        if (avs_s0_address == A_MASK)
            rd_mux = 32'(mask_q);
        else if (avs_s0_address == A_PEND)
            rd_mux = 32'(pend);
        else if (avs_s0_address == A_ID)
            rd_mux = ID_VAL;
    end

    assign readdata_d = avs_s0_read ? rd_mux : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= '0;
            done_q     <= '0;
            ovr_q      <= '0;
            crc_q      <= '0;
            err_cnt_q  <= '0;
            done_cnt_q <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            err_q      <= err_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            crc_q      <= crc_d;
            err_cnt_q  <= err_cnt_d;
            done_cnt_q <= done_cnt_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            rvalid_q   <= avs_s0_read;
            irq_q      <= |pend;
        end
    end

    assign avs_s0_readdata      = readdata_q;
    assign avs_s0_readdatavalid = rvalid_q;
    assign irq                  = irq_q;

endmodule

// File: tb/tb_spi_status_csr.sv
// Self-checking bench for spi_status_csr: directed steps plus a random phase,
// checked against a register-level model on a 16-bit and a 4-bit counter build.
module tb_spi_status_csr;

    localparam int NUM_CH = 4;
    localparam int CRC_W  = 32;
    localparam int ADDR_W = 12;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    avs_write = 1'b0;
    logic                    avs_read = 1'b0;
    logic [ADDR_W-1:0]       avs_addr = '0;
    logic [31:0]             avs_wdata = '0;
    logic [NUM_CH-1:0]       ch_error = '0;
    logic [NUM_CH-1:0]       ch_done = '0;
    logic [NUM_CH*CRC_W-1:0] crc_out = '0;
    logic [31:0]             rdata, rdata4;
    logic                    rvalid, rvalid4;
    logic                    irq_o, irq4;

    spi_status_csr #(.NUM_CH(NUM_CH), .CRC_W(CRC_W), .CNT_W(16), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .avs_s0_write(avs_write), .avs_s0_read(avs_read),
        .avs_s0_address(avs_addr), .avs_s0_writedata(avs_wdata),
        .avs_s0_readdata(rdata), .avs_s0_readdatavalid(rvalid),
        .ch_error(ch_error), .ch_done(ch_done), .crc_out(crc_out), .irq(irq_o)
    );

    spi_status_csr #(.NUM_CH(NUM_CH), .CRC_W(CRC_W), .CNT_W(4), .ADDR_W(ADDR_W)) dut4 (
        .clk(clk), .rst(rst),
        .avs_s0_write(avs_write), .avs_s0_read(avs_read),
        .avs_s0_address(avs_addr), .avs_s0_writedata(avs_wdata),
        .avs_s0_readdata(rdata4), .avs_s0_readdatavalid(rvalid4),
        .ch_error(ch_error), .ch_done(ch_done), .crc_out(crc_out), .irq(irq4)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: counters hold raw event counts since the last clear and
    // are saturated only when read, so one model serves both counter widths.
    bit          m_err [NUM_CH];
    bit          m_done[NUM_CH];
    bit          m_ovr [NUM_CH];
    logic [31:0] m_crc [NUM_CH];
    int          m_ecnt[NUM_CH];
    int          m_dcnt[NUM_CH];
    logic [3:0]  m_mask;

    logic [31:0] exp_q[$];
    logic [31:0] exp4_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [31:0] sat(int n, int w);
        int top = (1 << w) - 1;
        return (n > top) ? 32'(top) : 32'(n);
    endfunction

    function automatic logic [3:0] model_pend();
        logic [3:0] p = '0;
        for (int c = 0; c < NUM_CH; c++) p[c] = (m_err[c] | m_done[c]) & m_mask[c];
        return p;
    endfunction

    function automatic logic [31:0] model_read(logic [ADDR_W-1:0] a, int cntw);
        int ai = int'(a);
        if (ai < NUM_CH * 8) begin
            int c = ai / 8;
            case (ai % 8)
                0: return {29'd0, m_ovr[c], m_done[c], m_err[c]};
                1: return m_crc[c];
                2: return sat(m_ecnt[c], cntw);
                3: return sat(m_dcnt[c], cntw);
                default: return 32'd0;
            endcase
        end
        if (ai == 'h80) return {28'd0, m_mask};
        if (ai == 'h81) return {28'd0, model_pend()};
        if (ai == 'h83) return {8'h53, 8'(NUM_CH), 8'(CRC_W), 8'(cntw)};
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_err[c] = 0; m_done[c] = 0; m_ovr[c] = 0;
            m_crc[c] = '0; m_ecnt[c] = 0; m_dcnt[c] = 0;
        end
        m_mask = '0;
    endtask

    task automatic model_update(bit w, logic [ADDR_W-1:0] a, logic [31:0] wd,
                                logic [3:0] e, logic [3:0] d, logic [127:0] crc);
        bit ctrl_clr = w && (int'(a) == 'h82) && wd[0];
        for (int c = 0; c < NUM_CH; c++) begin
            bit w_stat   = w && (int'(a) == c * 8);
            bit old_done = m_done[c];
            if (ctrl_clr || (w_stat && wd[0])) m_err[c] = 0;
            if (ctrl_clr || (w_stat && wd[1])) m_done[c] = 0;
            if (ctrl_clr || (w_stat && wd[2])) m_ovr[c] = 0;
            if (e[c]) m_err[c] = 1;
            if (d[c]) begin
                if (old_done) m_ovr[c] = 1;
                m_done[c] = 1;
                m_crc[c]  = crc[c*32 +: 32];
            end
            if (ctrl_clr || (w && int'(a) == c * 8 + 2)) m_ecnt[c] = 0;
            if (ctrl_clr || (w && int'(a) == c * 8 + 3)) m_dcnt[c] = 0;
            m_ecnt[c] += int'(e[c]);
            m_dcnt[c] += int'(d[c]);
        end
        if (w && int'(a) == 'h80) m_mask = wd[3:0];
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: one bus/event cycle, then check every output of both builds.
    task automatic step(string tag, bit r, bit w, bit rd, logic [ADDR_W-1:0] a,
                        logic [31:0] wd, logic [3:0] e, logic [3:0] d, logic [127:0] crc);
        bit          exp_irq;
        bit          exp_rv;
        logic [31:0] exp_d, exp_d4;
        rst = r; avs_write = w; avs_read = rd; avs_addr = a;
        avs_wdata = wd; ch_error = e; ch_done = d; crc_out = crc;
        exp_irq = r ? 1'b0 : |model_pend();
        exp_rv  = rd && !r;
        if (exp_rv) begin
            exp_q.push_back(model_read(a, 16));
            exp4_q.push_back(model_read(a, 4));
        end
        if (r) model_reset();
        else   model_update(w, a, wd, e, d, crc);
        @(posedge clk);
        #1;
        check({tag, " rvalid"}, 32'(rvalid), 32'(exp_rv));
        check({tag, " rvalid4"}, 32'(rvalid4), 32'(exp_rv));
        exp_d  = exp_rv ? exp_q.pop_front()  : 32'd0;
        exp_d4 = exp_rv ? exp4_q.pop_front() : 32'd0;
        check($sformatf("%s rdata a=%h", tag, a), rdata, exp_d);
        check($sformatf("%s rdata4 a=%h", tag, a), rdata4, exp_d4);
        check({tag, " irq"}, 32'(irq_o), 32'(exp_irq));
        check({tag, " irq4"}, 32'(irq4), 32'(exp_irq));
        rst = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
        ch_error = '0; ch_done = '0;
    endtask

    task automatic rd(string tag, logic [ADDR_W-1:0] a);
        step(tag, 0, 0, 1, a, '0, '0, '0, '0);
    endtask

    task automatic wr(string tag, logic [ADDR_W-1:0] a, logic [31:0] wd);
        step(tag, 0, 1, 0, a, wd, '0, '0, '0);
    endtask

    task automatic idle(string tag);
        step(tag, 0, 0, 0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [127:0]      crc;
        model_reset();

        // reset state
        step("reset", 1, 0, 0, '0, '0, '0, '0, '0);
        step("reset", 1, 0, 0, '0, '0, '0, '0, '0);
        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 4; o++) rd("rst_rd", ADDR_W'(c * 8 + o));
        for (int g = 'h80; g <= 'h83; g++) rd("rst_glb", ADDR_W'(g));

        // done capture, snapshot and overrun on channel 2
        crc = '0; crc[64 +: 32] = 32'hDEADBEEF;
        step("done2", 0, 0, 0, '0, '0, 4'b0000, 4'b0100, crc);
        rd("done2", 12'h010); rd("done2", 12'h011); rd("done2", 12'h013);
        crc[64 +: 32] = 32'h12345678;
        step("done2b", 0, 0, 0, '0, '0, 4'b0000, 4'b0100, crc);
        rd("ovr2", 12'h010); rd("ovr2", 12'h011); rd("ovr2", 12'h013);
        wr("clr2", 12'h010, 32'h7);
        rd("clr2", 12'h010);

        // masked interrupt on channel 0
        wr("mask", 12'h080, 32'h1);
        step("err0", 0, 0, 0, '0, '0, 4'b0001, 4'b0000, '0);
        idle("irq_on");
        rd("pend", 12'h081);
        wr("w1c0", 12'h000, 32'h1);
        idle("irq_off");
        rd("stat0", 12'h000);

        // event beats W1C in the same cycle, then CTRL clear-all
        step("err1_w1c", 0, 1, 0, 12'h008, 32'h1, 4'b0010, 4'b0000, '0);
        rd("err1", 12'h008); rd("err1", 12'h00A);
        wr("ctrl", 12'h082, 32'h1);
        rd("ctrl", 12'h00A); rd("ctrl", 12'h008); rd("ctrl", 12'h082);

        // counter saturation on channel 3 (4-bit build saturates at 15)
        for (int i = 0; i < 20; i++) step("err3", 0, 0, 0, '0, '0, 4'b1000, 4'b0000, '0);
        rd("sat", 12'h01A);
        wr("cnt_clr", 12'h01A, 32'hFFFF_FFFF);
        rd("cnt_clr", 12'h01A);
        step("cnt_wr_inc", 0, 1, 0, 12'h01A, 32'h0, 4'b1000, 4'b0000, '0);
        rd("cnt_wr_inc", 12'h01A);

        // unmapped addresses
        rd("unmap", 12'h020); rd("unmap", 12'h085); rd("unmap", 12'h084);
        rd("unmap", 12'h007); rd("unmap", 12'h00C);
        wr("unmap_wr", 12'h021, 32'hFFFF_FFFF);
        rd("unmap_wr", 12'h021);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit         w, r;
            logic [3:0] e, d;
            if ($urandom_range(0, 11) < 9)
                a = ADDR_W'($urandom_range(0, NUM_CH - 1) * 8 + $urandom_range(0, 5));
            else
                a = ADDR_W'('h80 + $urandom_range(0, 5));
            w = ($urandom_range(0, 9) < 2);
            r = w ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
            e = 4'($urandom) & 4'($urandom) & 4'($urandom);
            d = 4'($urandom) & 4'($urandom) & 4'($urandom);
            crc = {$urandom, $urandom, $urandom, $urandom};
            step("rand", 0, w, r, a, $urandom, e, d, crc);
        end

        // reset kills a pending read
        rd("pre_rst", 12'h083);
        step("rst_rd", 1, 0, 1, 12'h083, '0, '0, '0, '0);
        rd("post_rst", 12'h080);
        rd("post_rst", 12'h083);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_status_csr.md
Name: spi_status_csr

Overview:
- Parametrised Avalon-MM status/CSR slave for NUM_CH SpeedSPI channels. It is the multi-channel successor of the single-channel error/CRC readback port.
- Captures per-channel error and done events into sticky W1C status bits, snapshots the CRC on each done, and keeps saturating event counters.
- Drives a maskable, level-sensitive interrupt to the host CPU.
- Registered read path with explicit readdatavalid.

Parameters:
- NUM_CH, 4, number of SPI channels (1..16)
- CRC_W, 32, CRC width per channel (1..32); zero-extended on readback
- CNT_W, 16, width of per-channel error/done counters (1..32)
- ADDR_W, 12, Avalon word-address width (>= 8)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- avs_s0_write  in  1  Avalon write strobe
- avs_s0_read  in  1  Avalon read strobe
- avs_s0_address  in  ADDR_W  word address
- avs_s0_writedata  in  32  write data
- avs_s0_readdata  out  32  registered read data
- avs_s0_readdatavalid  out  1  read data valid, one cycle after read
- ch_error  in  NUM_CH  per-channel error pulse, 1 clk wide per event
- ch_done  in  NUM_CH  per-channel transfer-complete pulse
- crc_out  in  NUM_CH*CRC_W  per-channel live CRC; channel c occupies bits [c*CRC_W +: CRC_W]
- irq  out  1  registered interrupt request, level

Behaviour:
- Reset: clk and synchronous active-high rst, as stated in Ports. During rst, all of the following clear to 0: STATUS, CRC snapshots, counters, IRQ_MASK, readdata, readdatavalid, irq. Reset mid-read kills the pending readdatavalid.
- Address map, channel c (c < NUM_CH), base = c*8:
  - +0 STATUS: bit0 ERR sticky, bit1 DONE sticky, bit2 OVR (done arrived while DONE already set); W1C on bits 2:0.
  - +1 CRC_SNAP: CRC_W bits, zero-extended; loaded from crc_out slice in the cycle ch_done[c]=1.
  - +2 ERR_CNT: CNT_W bits; increments on ch_error[c]; saturates at all-ones; any write clears it.
  - +3 DONE_CNT: same rules as ERR_CNT, driven by ch_done[c].
  - +4..+7 read 0; writes ignored.
- Global registers:
  - 0x80 IRQ_MASK: NUM_CH bits, R/W.
  - 0x81 IRQ_PEND: read-only, bit c = (ERR[c] | DONE[c]) & mask[c].
  - 0x82 CTRL: write bit0=1 clears all STATUS and counters in one cycle; reads 0.
  - 0x83 ID: reads {8'h53, 8'(NUM_CH), 8'(CRC_W), 8'(CNT_W)}.
  - Any other address, including channel bases >= NUM_CH: reads 0, writes ignored.
- Read timing:
  - read asserted in cycle N -> readdata and readdatavalid=1 in cycle N+1.
  - In all other cycles readdata=0 and readdatavalid=0.
  - Back-to-back reads are accepted every cycle; no waitrequest.
- Read data source: value as it stands before any same-cycle event or write update. Write and read in the same cycle is illegal on the bus; if it occurs, the write applies and the read returns the pre-write value.
- Event-vs-clear priority:
  - Event pulse and W1C or CTRL clear in the same cycle: set wins (bit stays 1); counter ends at 1.
  - Counter write and increment in the same cycle: counter = 1.
- OVR sets only when ch_done[c]=1 and DONE[c] is already 1 at the start of the cycle. The CRC snapshot still updates on an overrun (newest wins).
- Simultaneous ch_error and ch_done on one channel: both bits set, both counters increment.
- irq is registered: irq(N+1) = OR of IRQ_PEND(N). It deasserts one cycle after the last pending bit clears or is masked.
- Width rules: all registers are zero-extended to 32 bits on read. Only the low NUM_CH bits of IRQ_MASK are stored.

Test Plan:
- Reset, then read each channel's +0..+3 and 0x80..0x82 -> all 0; read 0x83 with defaults -> 0x53042010; readdatavalid high exactly one cycle after each read.
- ch_done[2] pulse with crc_out slice 2 = 0xDEADBEEF -> STATUS@0x10=0x2, CRC_SNAP@0x11=0xDEADBEEF, DONE_CNT@0x13=1; second done with 0x12345678 -> STATUS=0x6, snapshot=0x12345678, DONE_CNT=2.
- IRQ_MASK=0x1, then ch_error[0] pulse -> irq=1 two cycles after the pulse, IRQ_PEND=0x1; write 0x1 to 0x00 -> STATUS=0, irq=0 on the following cycle.
- ch_error[1] pulse in the same cycle as a W1C write of 0x1 to 0x08 -> ERR stays 1, ERR_CNT=1; CTRL write of 0x1 then clears all, and a subsequent read of 0x0A returns 0.
- CNT_W=4: 20 error pulses on channel 3 -> ERR_CNT@0x1A=15 (saturated); any write to 0x1A -> 0.
- Read 0x20 with NUM_CH=4, and read 0x85 -> 0 with readdatavalid=1; reset asserted in the cycle after a read -> readdatavalid=0.
